sa_reset_seq: RTL and testbench
===============================

SA_RESET_SEQ -- requirements
Module: sa_reset_seq

Interface
REQ-001 Parameter NUM_CH, default 4: number of sequenced reset outputs, legal 1..8.
REQ-002 Parameter SYNC_DEPTH, default 2: synchroniser flop stages, legal 2..4.
REQ-003 Parameter RELEASE_GAP, default 16: clk cycles between successive channel releases and the sw-reset hold-off, legal 1..255.
REQ-004 clk  input  1  single clock for all sequential logic.
REQ-005 inreset_  input  1  reset, asynchronous, active-low; asserts all outputs immediately, deassertion synchronised.
REQ-006 direct_reset_  input  1  active-low reset used in place of inreset_ when test_mode=1.
REQ-007 test_mode  input  1  DFT bypass select.
REQ-008 sw_reset  input  NUM_CH  per-channel synchronous reset request, active-high.
REQ-009 outreset_  output  NUM_CH  per-channel active-low reset, released in index order.
REQ-010 seq_done  output  1  high when sequence complete and no channel held by sw_reset.

Function
REQ-011 Internal sync_rst_ SHALL be cleared asynchronously by inreset_ low and SHALL go high on the SYNC_DEPTH-th rising clk edge after inreset_ deasserts.
REQ-012 FSM states SHALL be S_HOLD, S_GAP and S_DONE; reset state S_HOLD.
REQ-013 S_HOLD -> S_GAP once sync_rst_ is high; gap_cnt=0, ch_idx=0.
REQ-014 In S_GAP gap_cnt SHALL increment each edge; at gap_cnt==RELEASE_GAP-1 it releases channel ch_idx, clears gap_cnt, and increments ch_idx, or goes to S_DONE if ch_idx==NUM_CH-1.
REQ-015 Channel i SHALL first go high at edge SYNC_DEPTH+(i+1)*RELEASE_GAP after inreset_ deassertion; seq_done SHALL rise one edge after the last channel release.
REQ-016 sw_reset[k]=1 SHALL drive outreset_[k] low on the next edge in any state and hold it low while sw_reset[k]=1.
REQ-017 Per-channel hold_cnt[k] SHALL load RELEASE_GAP while sw_reset[k]=1 and decrement to 0 afterwards; outreset_[k] is high only when the sequence has passed channel k and hold_cnt[k]==0.
REQ-018 sw_reset on a channel not yet released SHALL neither stall nor alter the sequence timing of other channels.
REQ-019 seq_done SHALL be registered and equal (state==S_DONE) AND (all hold_cnt==0) AND (sw_reset==0).
REQ-020 test_mode=1 SHALL select direct_reset_ as the async clear of all flops and drive every outreset_ bit combinationally from direct_reset_; seq_done is unaffected by the output mux.
REQ-021 Counters SHALL be $clog2(RELEASE_GAP+1) bits wide and SHALL never wrap.

Reset
REQ-022 inreset_ low (test_mode=0) at any time, including mid-sequence, SHALL asynchronously set outreset_=0, seq_done=0, state=S_HOLD, and all counters and ch_idx to 0.
REQ-023 After reset release the full sequence of REQ-015 SHALL restart from channel 0.

Structure
REQ-024 Package sa_reset_pkg SHALL hold the state enum type and the parameter legal-range constants.
REQ-025 Sub-module sa_reset_sync_chain SHALL implement the SYNC_DEPTH-stage synchroniser with the test-mode clear mux; it is instantiated once.

Verification (NUM_CH=4, SYNC_DEPTH=2, RELEASE_GAP=3)
REQ-026 Release inreset_ -> outreset_ bits 0..3 rise at edges 5, 8, 11, 14; seq_done rises at edge 15.
REQ-027 inreset_ low at edge 9, between 8 and 11 -> outreset_=0000 and seq_done=0 with no clock edge; after re-release, bit 0 rises at edge 5 again.
REQ-028 In S_DONE, sw_reset[2]=1 for 4 cycles -> outreset_[2]=0 on the next edge and seq_done=0; outreset_[2] returns high 3 edges after sw_reset falls, and seq_done rises one edge after that.
REQ-029 sw_reset[3]=1 from edge 1 to edge 20 -> bits 0..2 rise at 5, 8, 11; bit 3 rises 3 edges after edge 20.
REQ-030 test_mode=1, toggle direct_reset_ -> all outreset_ follow it combinationally; inreset_ toggles have no effect on the outputs.
REQ-031 Sweep RELEASE_GAP=1 and NUM_CH=1 -> the single channel rises at edge 3 and seq_done rises at edge 4.

Source files
------------

// File: rtl/sa_reset_pkg.sv
// Shared types and parameter limits for the sequenced reset generator.
package sa_reset_pkg;

    typedef enum logic [1:0] {
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    localparam int NUM_CH_MIN      = 1;
    localparam int NUM_CH_MAX      = 8;
    localparam int SYNC_DEPTH_MIN  = 2;
    localparam int SYNC_DEPTH_MAX  = 4;
    localparam int RELEASE_GAP_MIN = 1;
    localparam int RELEASE_GAP_MAX = 255;

endpackage

// File: rtl/sa_reset_sync_chain.sv
// Reset synchroniser: async assert, synchronised deassert, with the DFT
// selection between the functional and direct reset as the async clear.
module sa_reset_sync_chain
    import sa_reset_pkg::*;
#(
    parameter int SYNC_DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_inreset_n,
    input  logic i_direct_reset_n,
    input  logic i_test_mode,
    output logic o_arst_n,
    output logic o_sync_rst_n
);

    logic                  w_arst_n;
    logic [SYNC_DEPTH-1:0] r_sync;

    assign w_arst_n = i_test_mode ? i_direct_reset_n : i_inreset_n;

    // A one shifts in from stage 0; the last stage is high after SYNC_DEPTH edges.
    always_ff @(posedge i_clk or negedge w_arst_n) begin
        if (!w_arst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign o_arst_n     = w_arst_n;
    assign o_sync_rst_n = r_sync[SYNC_DEPTH-1];

endmodule

// File: rtl/sa_reset_seq.sv
// Sequenced reset generator: releases NUM_CH active-low resets one by one,
// RELEASE_GAP cycles apart, with per-channel software reset and hold-off.
module sa_reset_seq
    import sa_reset_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_DEPTH  = 2,
    parameter int RELEASE_GAP = 16
) (
    input  logic              clk,
    input  logic              inreset_,
    input  logic              direct_reset_,
    input  logic              test_mode,
    input  logic [NUM_CH-1:0] sw_reset,
    output logic [NUM_CH-1:0] outreset_,
    output logic              seq_done
);

    localparam int CNT_W = $clog2(RELEASE_GAP + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    if ((NUM_CH < NUM_CH_MIN) || (NUM_CH > NUM_CH_MAX) ||
        (SYNC_DEPTH < SYNC_DEPTH_MIN) || (SYNC_DEPTH > SYNC_DEPTH_MAX) ||
        (RELEASE_GAP < RELEASE_GAP_MIN) || (RELEASE_GAP > RELEASE_GAP_MAX)) begin : g_bad_param
        $error("sa_reset_seq: parameter out of legal range");
    end

    logic              w_arst_n;
    logic              w_sync_rst_n;
    logic              w_counting;
    logic              w_release_now;
    logic              w_hold_idle;
    logic [NUM_CH-1:0] w_hold_clear;

    state_t            r_state;
    logic [CNT_W-1:0]  r_gap_cnt;
    logic [IDX_W-1:0]  r_ch_idx;
    logic [NUM_CH-1:0] r_passed;
    logic [NUM_CH-1:0] r_outreset;
    logic              r_seq_done;
    logic [CNT_W-1:0]  r_hold [NUM_CH];

    sa_reset_sync_chain #(
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_sync (
        .i_clk            (clk),
        .i_inreset_n      (inreset_),
        .i_direct_reset_n (direct_reset_),
        .i_test_mode      (test_mode),
        .o_arst_n         (w_arst_n),
        .o_sync_rst_n     (w_sync_rst_n)
    );

    // The edge that leaves S_HOLD already counts as the first gap cycle, so
    // channel i lands exactly (i+1)*RELEASE_GAP edges after sync release.
    always_comb begin
        w_counting    = (r_state == S_GAP) || ((r_state == S_HOLD) && w_sync_rst_n);
        w_release_now = w_counting && (r_gap_cnt == GAP_LAST);
        w_hold_idle   = 1'b1;
        w_hold_clear  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_hold_clear[k] = !sw_reset[k] && (r_hold[k] <= CNT_W'(1));
            if (r_hold[k] != '0) begin
                w_hold_idle = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge w_arst_n) begin
        if (!w_arst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sw_reset[k]) begin
                    r_hold[k] <= CNT_W'(RELEASE_GAP);
                end else if (r_hold[k] != '0) begin
                    r_hold[k] <= r_hold[k] - 1'b1;
                end
            end
        end
    end

    // Outputs are built from next-cycle values so they stay glitch-free registers.
    always_ff @(posedge clk or negedge w_arst_n) begin
        if (!w_arst_n) begin
            r_state    <= S_HOLD;
            r_gap_cnt  <= '0;
            r_ch_idx   <= '0;
            r_passed   <= '0;
            r_outreset <= '0;
            r_seq_done <= 1'b0;
        end else begin
            r_seq_done <= (r_state == S_DONE) && w_hold_idle && (sw_reset == '0);
            for (int k = 0; k < NUM_CH; k++) begin
                r_outreset[k] <= (r_passed[k] || (w_release_now && (r_ch_idx == IDX_W'(k))))
                                 && w_hold_clear[k];
                if (w_release_now && (r_ch_idx == IDX_W'(k))) begin
                    r_passed[k] <= 1'b1;
                end
            end
            case (r_state)
                S_HOLD, S_GAP: begin
                    if (w_counting) begin
                        if (w_release_now) begin
                            r_gap_cnt <= '0;
                            if (r_ch_idx == IDX_LAST) begin
                                r_state <= S_DONE;
                            end else begin
                                r_ch_idx <= r_ch_idx + 1'b1;
                                r_state  <= S_GAP;
                            end
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                            r_state   <= S_GAP;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

    assign outreset_ = test_mode ? {NUM_CH{direct_reset_}} : r_outreset;
    assign seq_done  = r_seq_done;

endmodule

// File: tb/tb_sa_reset_seq.sv
// Directed self-checking bench for sa_reset_seq (4ch/gap 3, plus 1ch/gap 1).
module tb_sa_reset_seq;

    logic       clk;
    logic       inreset_;
    logic       direct_reset_;
    logic       test_mode;
    logic [3:0] sw_reset;
    logic [3:0] outreset_;
    logic       seq_done;
    logic [0:0] sw1;
    logic [0:0] out1;
    logic       done1;

    int total;
    int bad;
    logic [3:0] expOut;

    sa_reset_seq #(
        .NUM_CH      (4),
        .SYNC_DEPTH  (2),
        .RELEASE_GAP (3)
    ) dut (
        .clk           (clk),
        .inreset_      (inreset_),
        .direct_reset_ (direct_reset_),
        .test_mode     (test_mode),
        .sw_reset      (sw_reset),
        .outreset_     (outreset_),
        .seq_done      (seq_done)
    );

    sa_reset_seq #(
        .NUM_CH      (1),
        .SYNC_DEPTH  (2),
        .RELEASE_GAP (1)
    ) dut1 (
        .clk           (clk),
        .inreset_      (inreset_),
        .direct_reset_ (direct_reset_),
        .test_mode     (test_mode),
        .sw_reset      (sw1),
        .outreset_     (out1),
        .seq_done      (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rstN, input logic [3:0] sw);
        inreset_ = rstN;
        sw_reset = sw;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        test_mode     = 1'b0;
        direct_reset_ = 1'b1;
        sw1           = 1'b0;
        applyStimulus(1'b1, 4'h0);
        #2;

        // Reset state, then a full release sequence on both instances.
        applyStimulus(1'b0, 4'h0);
        tick(3);
        checkOutput("rst_out", {4'h0, outreset_}, 8'h00);
        checkOutput("rst_done", {7'h0, seq_done}, 8'h00);
        checkOutput("rst_out1", {7'h0, out1}, 8'h00);
        checkOutput("rst_done1", {7'h0, done1}, 8'h00);
        applyStimulus(1'b1, 4'h0);
        for (int e = 1; e <= 16; e++) begin
            tick(1);
            for (int i = 0; i < 4; i++) expOut[i] = (e >= 5 + 3 * i);
            checkOutput($sformatf("seq_out_e%0d", e), {4'h0, outreset_}, {4'h0, expOut});
            checkOutput($sformatf("seq_done_e%0d", e), {7'h0, seq_done}, {7'h0, (e >= 15)});
            if (e <= 5) begin
                checkOutput($sformatf("ch1_out_e%0d", e), {7'h0, out1}, {7'h0, (e >= 3)});
                checkOutput($sformatf("ch1_done_e%0d", e), {7'h0, done1}, {7'h0, (e >= 4)});
            end
        end

        // Mid-sequence reset between channel 1 and channel 2 releases.
        applyStimulus(1'b0, 4'h0);
        tick(2);
        applyStimulus(1'b1, 4'h0);
        tick(9);
        checkOutput("mid_e9_out", {4'h0, outreset_}, 8'h03);
        #2;
        applyStimulus(1'b0, 4'h0);
        #1;
        checkOutput("async_clr_out", {4'h0, outreset_}, 8'h00);
        checkOutput("async_clr_done", {7'h0, seq_done}, 8'h00);
        tick(2);
        checkOutput("held_clr_out", {4'h0, outreset_}, 8'h00);
        applyStimulus(1'b1, 4'h0);
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            checkOutput($sformatf("restart_e%0d", e), {4'h0, outreset_}, (e >= 5) ? 8'h01 : 8'h00);
        end

        // Software reset of channel 2 after the sequence completes.
        tick(10);
        checkOutput("done_e15_out", {4'h0, outreset_}, 8'h0f);
        checkOutput("done_e15_done", {7'h0, seq_done}, 8'h01);
        applyStimulus(1'b1, 4'b0100);
        tick(1);
        checkOutput("sw2_e16_out", {4'h0, outreset_}, 8'h0b);
        checkOutput("sw2_e16_done", {7'h0, seq_done}, 8'h00);
        tick(3);
        checkOutput("sw2_e19_out", {4'h0, outreset_}, 8'h0b);
        applyStimulus(1'b1, 4'h0);
        tick(2);
        checkOutput("sw2_e21_out", {4'h0, outreset_}, 8'h0b);
        checkOutput("sw2_e21_done", {7'h0, seq_done}, 8'h00);
        tick(1);
        checkOutput("sw2_e22_out", {4'h0, outreset_}, 8'h0f);
        checkOutput("sw2_e22_done", {7'h0, seq_done}, 8'h00);
        tick(1);
        checkOutput("sw2_e23_done", {7'h0, seq_done}, 8'h01);

        // Channel 3 held by software reset from edge 1 to edge 20.
        applyStimulus(1'b0, 4'h0);
        tick(2);
        applyStimulus(1'b1, 4'b1000);
        for (int e = 1; e <= 24; e++) begin
            tick(1);
            for (int i = 0; i < 3; i++) expOut[i] = (e >= 5 + 3 * i);
            expOut[3] = (e >= 23);
            checkOutput($sformatf("sw3_out_e%0d", e), {4'h0, outreset_}, {4'h0, expOut});
            checkOutput($sformatf("sw3_done_e%0d", e), {7'h0, seq_done}, {7'h0, (e >= 24)});
            if (e == 20) applyStimulus(1'b1, 4'h0);
        end

        // Test mode: outputs follow direct_reset_, inreset_ is ignored.
        test_mode     = 1'b1;
        direct_reset_ = 1'b1;
        #1;
        checkOutput("tm_hi_out", {4'h0, outreset_}, 8'h0f);
        checkOutput("tm_hi_out1", {7'h0, out1}, 8'h01);
        direct_reset_ = 1'b0;
        #1;
        checkOutput("tm_lo_out", {4'h0, outreset_}, 8'h00);
        checkOutput("tm_lo_out1", {7'h0, out1}, 8'h00);
        checkOutput("tm_lo_done", {7'h0, seq_done}, 8'h00);
        applyStimulus(1'b0, 4'h0);
        #1;
        checkOutput("tm_inrst_lo_out", {4'h0, outreset_}, 8'h00);
        direct_reset_ = 1'b1;
        #1;
        checkOutput("tm_direct_hi_out", {4'h0, outreset_}, 8'h0f);
        applyStimulus(1'b1, 4'h0);
        #1;
        checkOutput("tm_inrst_hi_out", {4'h0, outreset_}, 8'h0f);
        applyStimulus(1'b0, 4'h0);
        #1;
        checkOutput("tm_inrst_lo2_out", {4'h0, outreset_}, 8'h0f);
        direct_reset_ = 1'b0;
        tick(1);
        checkOutput("tm_direct_lo_out", {4'h0, outreset_}, 8'h00);
        test_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
